// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: LSB-first full adder with carry flip-flop, one result per WIDTH+2 cycles.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             carry_preset;
    logic             b_bit, sum_bit, carry_next, last_bit;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_r;

    // Subtraction is A + ~B + 1: invert B bits and seed the carry with one.
    assign b_bit        = b_sr[0] ^ sub_r;
    assign carry_preset = sub;

    always_ff @(posedge clk) begin
        if (rst)
            sub_r <= 1'b0;
        else if (state == IDLE && start)
            sub_r <= sub;
    end
`else
    logic unused_sub;

    assign unused_sub   = sub;
    assign b_bit        = b_sr[0];
    assign carry_preset = 1'b0;
`endif

    assign sum_bit    = a_sr[0] ^ b_bit ^ carry;
    assign carry_next = (a_sr[0] & b_bit) | (a_sr[0] & carry) | (b_bit & carry);
    assign last_bit   = (cnt == CW'(WIDTH - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath; the final SHIFT edge also publishes the completed result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a_in;
                        b_sr   <= b_in;
                        res_sr <= '0;
                        cnt    <= '0;
                        carry  <= carry_preset;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
                    carry  <= carry_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum_out   <= {sum_bit, res_sr[WIDTH-1:1]};
                        carry_out <= carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8); honours SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .sub       (sub),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        a_in  = a;
        b_in  = b;
        sub   = s;
        start = 1'b1;
    endtask

    // One full operation starting in IDLE, with cycle-exact done/busy expectations.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input logic [WIDTH-1:0] exp_sum, input logic exp_carry);
        apply_stimulus(a, b, s);
        tick();
        start = 1'b0;
        check_output({tag, "_busy_e0"}, busy, 1'b1);
        for (int i = 1; i < WIDTH; i++) begin
            tick();
            check_output({tag, "_done_early"}, done, 1'b0);
            check_output({tag, "_busy_shift"}, busy, 1'b1);
        end
        tick();
        check_output({tag, "_done"}, done, 1'b1);
        check_output({tag, "_busy_done"}, busy, 1'b1);
        check_output({tag, "_sum"}, sum_out, exp_sum);
        check_output({tag, "_carry"}, carry_out, exp_carry);
        tick();
        check_output({tag, "_done_end"}, done, 1'b0);
        check_output({tag, "_busy_end"}, busy, 1'b0);
        check_output({tag, "_sum_hold"}, sum_out, exp_sum);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        sub   = 1'b0;
        tick();
        tick();
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_sum", sum_out, 8'h00);
        check_output("rst_carry", carry_out, 1'b0);
        rst = 1'b0;
        tick();

        run_op("add_25_1a", 8'h25, 8'h1A, 1'b0, 8'h3F, 1'b0);

        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("b2b_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        // Start pulse at E3 and operand changes after E0 must not disturb 0x11+0x22.
        apply_stimulus(8'h11, 8'h22, 1'b0);
        tick();
        start = 1'b0;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 4; i < WIDTH; i++) begin
            tick();
            check_output("ign_done_early", done, 1'b0);
        end
        tick();
        check_output("ign_done", done, 1'b1);
        check_output("ign_sum", sum_out, 8'h33);
        check_output("ign_carry", carry_out, 1'b0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            check_output("ign_no_second_done", done, 1'b0);
            check_output("ign_idle", busy, 1'b0);
        end

        // Reset at E4 of FF+FF aborts the operation without a done pulse.
        apply_stimulus(8'hFF, 8'hFF, 1'b0);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_output("abort_busy", busy, 1'b0);
        check_output("abort_done", done, 1'b0);
        check_output("abort_sum", sum_out, 8'h00);
        check_output("abort_carry", carry_out, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            check_output("abort_no_done", done, 1'b0);
        end
        run_op("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        apply_stimulus(8'h0F, 8'h01, 1'b0);
        tick();
        start = 1'b0;
        rst   = 1'b0;
        check_output("rst_prio_busy", busy, 1'b0);
        tick();
        check_output("rst_prio_still_idle", busy, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        run_op("sub_07_05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
`else
        run_op("nosub_05_07", 8'h05, 8'h07, 1'b1, 8'h0C, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
